elevator_motion_ctrl: RTL and testbench
=======================================

Name: elevator_motion_ctrl

Overview:
Motion/door controller that consumes the target floor from the elevator request arbiter. It drives the car motor and door, tracks the current floor, and returns the direction (up/down), current floor and per-floor request_done pulses to the arbiter, closing the control loop. It is a Moore FSM with travel and door timers, and sits directly downstream of the arbiter in the elevator top level.

Parameters:
FLOORS_NUM, 5, number of floors; W = $clog2(FLOORS_NUM) is the floor index width
FLOOR_TRAVEL_CYCLES, 4, clock cycles to move one floor (>=1)
DOOR_OPEN_CYCLES, 6, clock cycles the door stays open per stop (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
req_floor  input  W  target floor from the arbiter; equals curr_floor when no request is in the current direction
req_here  input  1  a request (new or pending) exists at curr_floor; the top level derives it from the arbiter's combined request vector
up  output  1  travel direction up, fed back to the arbiter
down  output  1  travel direction down, fed back to the arbiter
curr_floor  output  W  floor the car is at or last passed
request_done  output  FLOORS_NUM  one-hot, single-cycle pulse for the serviced floor
motor_up  output  1  drive car upward
motor_down  output  1  drive car downward
door_open  output  1  door open command

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled only at the clk rising edge.
- Reset values: state=IDLE, curr_floor=0, up=0, down=0, motor_up=0, motor_down=0, door_open=0, request_done=0, all counters=0. Reset has priority over every transition. Reset during any state, including mid-travel, returns the block to these values on the next edge; the floor-0 resync is accepted.
- Outputs are registered or decoded from the state register only; no input-to-output combinational path.
- motor_up=(state==MOVE_UP); motor_down=(state==MOVE_DOWN); door_open=(state==DOOR).
- IDLE: up=down=0.
  - If req_floor>curr_floor: go to MOVE_UP, set up=1.
  - Else if req_floor<curr_floor: go to MOVE_DOWN, set down=1.
  - Else if req_here: go to DOOR.
  - Else stay in IDLE.
  - Decision-to-motor latency is 1 cycle.
- MOVE_UP / MOVE_DOWN:
  - The travel counter counts 0..FLOOR_TRAVEL_CYCLES-1.
  - On the terminal count, curr_floor steps by +1 or -1 and the counter clears.
  - In that same cycle the next floor (nf) is compared with req_floor as sampled then. This lets a nearer request added mid-travel take effect.
  - If nf==req_floor, go to DOOR.
  - If nf is an end floor (FLOORS_NUM-1 going up, 0 going down), go to DOOR when req_here-equivalent applies; otherwise go to IDLE with the direction cleared.
  - curr_floor never wraps and never leaves 0..FLOORS_NUM-1.
  - Otherwise continue in the same direction.
- DOOR:
  - On the entry edge, request_done[curr_floor] is set to 1 for exactly one cycle; all other bits are 0.
  - The door counter counts 0..DOOR_OPEN_CYCLES-1; up/down hold their value while the door is open.
  - On expiry: if up && req_floor>curr_floor, go to MOVE_UP.
  - Else if down && req_floor<curr_floor, go to MOVE_DOWN.
  - Else go to IDLE with up=down=0. The arbiter then selects in idle mode on the following cycle.
- Simultaneous events: a req_floor change in the same cycle as a floor arrival is honoured. A request at curr_floor arriving while the door is open is serviced by the open door and does not produce an extra request_done pulse.
- Counter width: $clog2(max(FLOOR_TRAVEL_CYCLES, DOOR_OPEN_CYCLES)+1); the counter is shared and cleared on every state change.
- up and down are never both 1.

Optional Feature:
- Macro: ELEVATOR_DOOR_SENSOR_EN.
- Defined: adds input door_obstruct (1 bit). While in DOOR with door_obstruct=1, the door counter reloads to 0, so the door stays open until DOOR_OPEN_CYCLES consecutive unobstructed cycles have elapsed. request_done is not re-pulsed.
- Undefined: the port is absent and the door time is fixed at DOOR_OPEN_CYCLES.

Test Plan:
- All tests use FLOORS_NUM=5, FLOOR_TRAVEL_CYCLES=4, DOOR_OPEN_CYCLES=6.
- Reset: hold rst=1 for 2 cycles -> all outputs 0, curr_floor=0; after release with req_floor=0 and req_here=0, the block stays in IDLE.
- Idle at 0, req_floor=3 -> up=1 and motor_up=1 next cycle; curr_floor steps 1,2,3 at 4-cycle intervals; door_open=1 for 6 cycles; request_done=5'b01000 for 1 cycle.
- Door at 3 with up=1 and req_floor=3 -> IDLE with up=0 at expiry; then req_floor=1 -> down=1, arrival at 1 after 8 cycles, request_done=5'b00010.
- Idle at 0, req_floor=0, req_here=1 -> door_open with no motor cycle; request_done=5'b00001.
- Travelling up from 1 toward 4, req_floor changes to 2 before reaching floor 2 -> stops at 2; rst asserted mid-MOVE_UP -> next cycle motor_up=0, curr_floor=0.
- ELEVATOR_DOOR_SENSOR_EN defined: door_obstruct=1 for 3 cycles starting at door cycle 2 -> door_open lasts 6+2+3=11 cycles.

Source files
------------

// File: rtl/elevator_motion_ctrl_if.sv
// Arbiter <-> motion controller bundle: target floor in, direction/floor/done back.
// Carries door_obstruct only when ELEVATOR_DOOR_SENSOR_EN is defined.
interface elevator_motion_ctrl_if #(
  parameter int FLOORS_NUM = 5
);
  localparam int W = $clog2(FLOORS_NUM);

  logic [W-1:0]          req_floor;
  logic                  req_here;
  logic                  up;
  logic                  down;
  logic [W-1:0]          curr_floor;
  logic [FLOORS_NUM-1:0] request_done;
  logic                  motor_up;
  logic                  motor_down;
  logic                  door_open;
`ifdef ELEVATOR_DOOR_SENSOR_EN
  logic                  door_obstruct;
`endif

  modport master (
    output req_floor, req_here,
`ifdef ELEVATOR_DOOR_SENSOR_EN
    output door_obstruct,
`endif
    input  up, down, curr_floor, request_done,
    input  motor_up, motor_down, door_open
  );

  modport slave (
    input  req_floor, req_here,
`ifdef ELEVATOR_DOOR_SENSOR_EN
    input  door_obstruct,
`endif
    output up, down, curr_floor, request_done,
    output motor_up, motor_down, door_open
  );
endinterface

// File: rtl/elevator_motion_ctrl.sv
// Elevator motion/door Moore FSM with shared travel/door timer.
// ELEVATOR_DOOR_SENSOR_EN adds door_obstruct, which holds the door open.
module elevator_motion_ctrl #(
  parameter int FLOORS_NUM          = 5,
  parameter int FLOOR_TRAVEL_CYCLES = 4,
  parameter int DOOR_OPEN_CYCLES    = 6
) (
  input logic                 clk,
  input logic                 rst,
  elevator_motion_ctrl_if.slave bus
);
  localparam int W    = $clog2(FLOORS_NUM);
  localparam int MAXC = (FLOOR_TRAVEL_CYCLES > DOOR_OPEN_CYCLES) ?
                        FLOOR_TRAVEL_CYCLES : DOOR_OPEN_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] TRAVEL_LAST = CW'(FLOOR_TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_LAST   = CW'(DOOR_OPEN_CYCLES - 1);
  localparam logic [W-1:0]  TOP         = W'(FLOORS_NUM - 1);
  localparam logic [W-1:0]  BOTTOM      = '0;
  localparam logic [FLOORS_NUM-1:0] ONE = FLOORS_NUM'(1);

  typedef enum logic [1:0] {
    IDLE, MOVE_UP, MOVE_DOWN, DOOR
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [W-1:0]          floor;
  logic                  up_q;
  logic                  down_q;
  logic [FLOORS_NUM-1:0] done;
  logic [W-1:0]          nf_up;
  logic [W-1:0]          nf_dn;
  logic                  obstruct;

  assign nf_up = floor + 1'b1;
  assign nf_dn = floor - 1'b1;

`ifdef ELEVATOR_DOOR_SENSOR_EN
  assign obstruct = bus.door_obstruct;
`else
  assign obstruct = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      floor  <= '0;
      up_q   <= 1'b0;
      down_q <= 1'b0;
      done   <= '0;
    end else begin
      done <= '0;
      unique case (state)
        IDLE: begin
          up_q   <= 1'b0;
          down_q <= 1'b0;
          cnt    <= '0;
          if (bus.req_floor > floor) begin
            state <= MOVE_UP;
            up_q  <= 1'b1;
          end else if (bus.req_floor < floor) begin
            state  <= MOVE_DOWN;
            down_q <= 1'b1;
          end else if (bus.req_here) begin
            state <= DOOR;
            done  <= ONE << floor;
          end
        end
        MOVE_UP: begin
          if (floor == TOP) begin
            state <= IDLE;
            up_q  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == TRAVEL_LAST) begin
            cnt   <= '0;
            floor <= nf_up;
            // req_floor sampled at arrival so a nearer late request wins
            if (bus.req_floor == nf_up) begin
              state <= DOOR;
              done  <= ONE << nf_up;
            end else if (nf_up == TOP) begin
              state <= IDLE;
              up_q  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MOVE_DOWN: begin
          if (floor == BOTTOM) begin
            state  <= IDLE;
            down_q <= 1'b0;
            cnt    <= '0;
          end else if (cnt == TRAVEL_LAST) begin
            cnt   <= '0;
            floor <= nf_dn;
            if (bus.req_floor == nf_dn) begin
              state <= DOOR;
              done  <= ONE << nf_dn;
            end else if (nf_dn == BOTTOM) begin
              state  <= IDLE;
              down_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DOOR: begin
          if (obstruct) begin
            cnt <= '0;
          end else if (cnt == DOOR_LAST) begin
            cnt <= '0;
            if (up_q && bus.req_floor > floor) begin
              state <= MOVE_UP;
            end else if (down_q && bus.req_floor < floor) begin
              state <= MOVE_DOWN;
            end else begin
              state  <= IDLE;
              up_q   <= 1'b0;
              down_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.up           = up_q;
  assign bus.down         = down_q;
  assign bus.curr_floor   = floor;
  assign bus.request_done = done;
  assign bus.motor_up     = (state == MOVE_UP);
  assign bus.motor_down   = (state == MOVE_DOWN);
  assign bus.door_open    = (state == DOOR);
endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Directed table-driven bench for elevator_motion_ctrl.
// Output bundle packed as {up,down,floor[2:0],done[4:0],motor_up,motor_down,door}.
module tb_elevator_motion_ctrl;
  localparam int F = 5;
  localparam int W = 3;
  localparam int NV = 19;

  logic clk;
  logic rst;

  elevator_motion_ctrl_if #(.FLOORS_NUM(F)) bus();

  elevator_motion_ctrl #(
    .FLOORS_NUM(F),
    .FLOOR_TRAVEL_CYCLES(4),
    .DOOR_OPEN_CYCLES(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [W-1:0] req;
    logic         here;
    int           cyc;
    logic [12:0]  exp;
  } vec_t;

  vec_t tbl[NV];
  int total;
  int bad;

  function automatic logic [12:0] e(
    input logic u, input logic d, input logic [2:0] fl,
    input logic [4:0] dn, input logic mu, input logic md,
    input logic dr);
    return {u, d, fl, dn, mu, md, dr};
  endfunction

  function automatic vec_t mk(
    input logic r, input int rq, input logic h,
    input int c, input logic [12:0] x);
    vec_t v;
    v.rst  = r;
    v.req  = W'(rq);
    v.here = h;
    v.cyc  = c;
    v.exp  = x;
    return v;
  endfunction

  function automatic logic [12:0] act();
    return {bus.up, bus.down, bus.curr_floor, bus.request_done,
            bus.motor_up, bus.motor_down, bus.door_open};
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [12:0] a,
                     input logic [12:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%b want=%b (u d flr done mu md door)",
               name, a, x);
    end
  endtask

  task automatic chk_int(input string name, input int a, input int x);
    total++;
    if (a != x) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, a, x);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req_floor = '0;
    bus.req_here  = 1'b0;
`ifdef ELEVATOR_DOOR_SENSOR_EN
    bus.door_obstruct = 1'b0;
`endif

    tbl[0]  = mk(1, 0, 0, 2, e(0, 0, 0, 5'b00000, 0, 0, 0));
    tbl[1]  = mk(0, 0, 0, 3, e(0, 0, 0, 5'b00000, 0, 0, 0));
    tbl[2]  = mk(0, 3, 0, 1, e(1, 0, 0, 5'b00000, 1, 0, 0));
    tbl[3]  = mk(0, 3, 0, 3, e(1, 0, 0, 5'b00000, 1, 0, 0));
    tbl[4]  = mk(0, 3, 0, 1, e(1, 0, 1, 5'b00000, 1, 0, 0));
    tbl[5]  = mk(0, 3, 0, 8, e(1, 0, 3, 5'b01000, 0, 0, 1));
    tbl[6]  = mk(0, 3, 0, 1, e(1, 0, 3, 5'b00000, 0, 0, 1));
    tbl[7]  = mk(0, 3, 0, 4, e(1, 0, 3, 5'b00000, 0, 0, 1));
    tbl[8]  = mk(0, 3, 0, 1, e(0, 0, 3, 5'b00000, 0, 0, 0));
    tbl[9]  = mk(0, 1, 0, 1, e(0, 1, 3, 5'b00000, 0, 1, 0));
    tbl[10] = mk(0, 1, 0, 4, e(0, 1, 2, 5'b00000, 0, 1, 0));
    tbl[11] = mk(0, 1, 0, 4, e(0, 1, 1, 5'b00010, 0, 0, 1));
    tbl[12] = mk(0, 1, 0, 6, e(0, 0, 1, 5'b00000, 0, 0, 0));
    tbl[13] = mk(0, 0, 0, 1, e(0, 1, 1, 5'b00000, 0, 1, 0));
    tbl[14] = mk(0, 0, 0, 4, e(0, 1, 0, 5'b00001, 0, 0, 1));
    tbl[15] = mk(0, 0, 0, 6, e(0, 0, 0, 5'b00000, 0, 0, 0));
    tbl[16] = mk(0, 0, 1, 1, e(0, 0, 0, 5'b00001, 0, 0, 1));
    tbl[17] = mk(0, 0, 1, 1, e(0, 0, 0, 5'b00000, 0, 0, 1));
    tbl[18] = mk(0, 0, 0, 5, e(0, 0, 0, 5'b00000, 0, 0, 0));

    for (int i = 0; i < NV; i++) begin
      rst           = tbl[i].rst;
      bus.req_floor = tbl[i].req;
      bus.req_here  = tbl[i].here;
      step(tbl[i].cyc);
      chk($sformatf("vec%0d", i), act(), tbl[i].exp);
    end

    // go to floor 1, then redirect a 1->4 trip to floor 2 at arrival
    bus.req_floor = 3'd1;
    step(5);
    chk("to1_arrive", act(), e(1, 0, 1, 5'b00010, 0, 0, 1));
    step(6);
    chk("to1_idle", act(), e(0, 0, 1, 5'b00000, 0, 0, 0));
    bus.req_floor = 3'd4;
    step(4);
    chk("to4_moving", act(), e(1, 0, 1, 5'b00000, 1, 0, 0));
    bus.req_floor = 3'd2;
    step(1);
    chk("redirect_stop2", act(), e(1, 0, 2, 5'b00100, 0, 0, 1));
    bus.req_floor = 3'd4;
    step(6);
    chk("door_continue_up", act(), e(1, 0, 2, 5'b00000, 1, 0, 0));
    step(2);
    rst = 1'b1;
    step(1);
    chk("rst_mid_move", act(), e(0, 0, 0, 5'b00000, 0, 0, 0));
    rst = 1'b0;
    bus.req_floor = 3'd0;
    step(2);
    chk("post_rst_idle", act(), e(0, 0, 0, 5'b00000, 0, 0, 0));

`ifdef ELEVATOR_DOOR_SENSOR_EN
    begin
      int n;
      int c;
      int pulses;
      bus.req_here = 1'b1;
      step(1);
      chk("obs_entry", act(), e(0, 0, 0, 5'b00001, 0, 0, 1));
      bus.req_here = 1'b0;
      n = 1;
      c = 0;
      pulses = 0;
      while (bus.door_open && c < 40) begin
        bus.door_obstruct = (c >= 2 && c <= 4);
        step(1);
        c++;
        if (bus.request_done != '0) pulses++;
        if (bus.door_open) n++;
      end
      bus.door_obstruct = 1'b0;
      chk_int("obs_door_len", n, 11);
      chk_int("obs_no_repulse", pulses, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
